// File: rtl/garage_door_actuator.sv
`default_nettype none
// ============================================================================
// Module      : garage_door_actuator
// Description : Motor actuator controller for a garage door. Translates the
//               level-sensitive open/close commands into motor winding drives.
//               It tracks door travel as a position count and inserts a dead
//               time between opposite travel directions. If an obstacle is
//               seen while closing, the door reverses automatically. A sticky
//               fault flag records conflicting commands.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TRAVEL_MAX    position count at full open (1..255)
//   DEAD_TIME     idle cycles between opposite travel directions (1..15)
// Ports
//   clk           in   1  rising-edge clock
//   reset         in   1  asynchronous active-high reset
//   motor_up      in   1  open command (level)
//   motor_down    in   1  close command (level)
//   obstacle      in   1  beam-break sensor, 1 = path blocked
//   drive_up      out  1  motor drive, open direction
//   drive_down    out  1  motor drive, close direction
//   door_position out  8  travel count, 0 = closed, TRAVEL_MAX = open
//   door_closed   out  1  door_position == 0
//   door_open     out  1  door_position == TRAVEL_MAX
//   state         out  3  CLOSED=0 OPENING=1 OPEN=2 CLOSING=3 STOPPED=4 DEAD=5
//   fault         out  1  sticky: both commands seen high together
// ============================================================================
module garage_door_actuator #(
  parameter int TRAVEL_MAX = 200,
  parameter int DEAD_TIME  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       motor_up,
  input  logic       motor_down,
  input  logic       obstacle,
  output logic       drive_up,
  output logic       drive_down,
  output logic [7:0] door_position,
  output logic       door_closed,
  output logic       door_open,
  output logic [2:0] state,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_CLOSED  = 3'd0,
    S_OPENING = 3'd1,
    S_OPEN    = 3'd2,
    S_CLOSING = 3'd3,
    S_STOPPED = 3'd4,
    S_DEAD    = 3'd5
  } state_t;

  localparam logic [7:0] c_TRAVEL_MAX = 8'(TRAVEL_MAX);
  localparam logic [3:0] c_DEAD_LOAD  = 4'(DEAD_TIME - 1);

  state_t     r_state;
  logic [7:0] r_pos;
  logic [3:0] r_dead_cnt;
  logic       r_target_up;   // direction to take when DEAD expires
  logic       r_rev;         // auto-reverse in progress after an obstacle
  logic       r_fault;

  logic       w_up_cmd;
  logic       w_dn_cmd;
  logic       w_no_cmd;
  logic       w_both;
  logic [7:0] w_pos_inc;
  logic [7:0] w_pos_dec;

  // Conflicting commands cancel each other and are treated as no command.
  assign w_up_cmd  = motor_up & ~motor_down;
  assign w_dn_cmd  = motor_down & ~motor_up;
  assign w_no_cmd  = ~w_up_cmd & ~w_dn_cmd;
  assign w_both    = motor_up & motor_down;
  assign w_pos_inc = r_pos + 8'd1;
  assign w_pos_dec = r_pos - 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_CLOSED;
      r_pos       <= 8'd0;
      r_dead_cnt  <= 4'd0;
      r_target_up <= 1'b0;
      r_rev       <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      if (w_both) begin
        r_fault <= 1'b1;
      end

      case (r_state)
        S_CLOSED: begin
          if (w_up_cmd) begin
            r_state <= S_OPENING;
          end
        end

        S_OPENING: begin
          // While auto-reversing, commands are ignored until fully open.
          if (!r_rev && w_no_cmd) begin
            r_state <= S_STOPPED;
          end else if (!r_rev && w_dn_cmd && !obstacle) begin
            r_state     <= S_DEAD;
            r_target_up <= 1'b0;
            r_dead_cnt  <= c_DEAD_LOAD;
          end else if (r_pos >= c_TRAVEL_MAX) begin
            // Re-entered OPENING while already at the top (e.g. via STOPPED).
            r_state <= S_OPEN;
            r_rev   <= 1'b0;
          end else begin
            r_pos <= w_pos_inc;
            if (w_pos_inc == c_TRAVEL_MAX) begin
              r_state <= S_OPEN;
              r_rev   <= 1'b0;
            end
          end
        end

        S_OPEN: begin
          if (w_dn_cmd && !obstacle) begin
            r_state <= S_CLOSING;
          end
        end

        S_CLOSING: begin
          if (obstacle) begin
            r_state     <= S_DEAD;
            r_target_up <= 1'b1;
            r_rev       <= 1'b1;
            r_dead_cnt  <= c_DEAD_LOAD;
          end else if (w_no_cmd) begin
            r_state <= S_STOPPED;
          end else if (w_up_cmd) begin
            r_state     <= S_DEAD;
            r_target_up <= 1'b1;
            r_dead_cnt  <= c_DEAD_LOAD;
          end else if (r_pos == 8'd0) begin
            r_state <= S_CLOSED;
          end else begin
            r_pos <= w_pos_dec;
            if (w_pos_dec == 8'd0) begin
              r_state <= S_CLOSED;
            end
          end
        end

        S_STOPPED: begin
          if (w_up_cmd) begin
            r_state <= S_OPENING;
          end else if (w_dn_cmd && !obstacle) begin
            r_state <= S_CLOSING;
          end
        end

        S_DEAD: begin
          if (r_dead_cnt == 4'd0) begin
            if (r_target_up) begin
              r_state <= S_OPENING;
            end else if (obstacle) begin
              // Never start closing into a blocked beam.
              r_state <= S_STOPPED;
            end else begin
              r_state <= S_CLOSING;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt - 4'd1;
          end
        end

        default: begin
          r_state <= S_STOPPED;
        end
      endcase
    end
  end

  // Drives decode straight from the state register so an asynchronous reset
  // removes motor power immediately.
  assign drive_up      = (r_state == S_OPENING);
  assign drive_down    = (r_state == S_CLOSING);
  assign door_position = r_pos;
  assign door_closed   = (r_pos == 8'd0);
  assign door_open     = (r_pos == c_TRAVEL_MAX);
  assign state         = r_state;
  assign fault         = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_garage_door_actuator.sv
`default_nettype none
// ============================================================================
// Module      : tb_garage_door_actuator
// Description : Self-checking bench for garage_door_actuator (TRAVEL_MAX=8,
//               DEAD_TIME=2). It runs directed scenarios and then randomized
//               command bursts. The outputs are compared every cycle against
//               a behavioural model of the door.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_garage_door_actuator;

  localparam int TM = 8;
  localparam int DT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       motor_up;
  logic       motor_down;
  logic       obstacle;
  logic       drive_up;
  logic       drive_down;
  logic [7:0] door_position;
  logic       door_closed;
  logic       door_open;
  logic [2:0] state;
  logic       fault;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural door model: state numbers are the published output codes.
  int m_state;
  int m_pos;
  int m_fault;
  int m_rev;
  int m_dead_left;   // DEAD edges still to spend
  int m_target;

  garage_door_actuator #(.TRAVEL_MAX(TM), .DEAD_TIME(DT)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .motor_up     (motor_up),
    .motor_down   (motor_down),
    .obstacle     (obstacle),
    .drive_up     (drive_up),
    .drive_down   (drive_down),
    .door_position(door_position),
    .door_closed  (door_closed),
    .door_open    (door_open),
    .state        (state),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pos = 0; m_fault = 0; m_rev = 0; m_dead_left = 0; m_target = 0;
  endtask

  task automatic model_edge(input bit up, input bit dn, input bit obs);
    bit up_c, dn_c, none;
    up_c = up && !dn;
    dn_c = dn && !up;
    none = !up_c && !dn_c;
    if (up && dn) m_fault = 1;
    case (m_state)
      0: if (up_c) m_state = 1;
      1: begin
        if (m_rev == 0 && none) m_state = 4;
        else if (m_rev == 0 && dn_c && !obs) begin
          m_state = 5; m_target = 3; m_dead_left = DT;
        end else begin
          if (m_pos < TM) m_pos = m_pos + 1;
          if (m_pos == TM) begin m_state = 2; m_rev = 0; end
        end
      end
      2: if (dn_c && !obs) m_state = 3;
      3: begin
        if (obs) begin
          m_state = 5; m_target = 1; m_rev = 1; m_dead_left = DT;
        end else if (none) m_state = 4;
        else if (up_c) begin
          m_state = 5; m_target = 1; m_dead_left = DT;
        end else begin
          if (m_pos > 0) m_pos = m_pos - 1;
          if (m_pos == 0) m_state = 0;
        end
      end
      4: begin
        if (up_c) m_state = 1;
        else if (dn_c && !obs) m_state = 3;
      end
      5: begin
        m_dead_left = m_dead_left - 1;
        if (m_dead_left == 0) begin
          if (m_target == 3 && obs) m_state = 4;
          else m_state = m_target;
        end
      end
      default: m_state = 4;
    endcase
  endtask

  task automatic check_all(input string where);
    check_eq({where, " state"},       32'(state),         32'(m_state));
    check_eq({where, " position"},    32'(door_position), 32'(m_pos));
    check_eq({where, " drive_up"},    32'(drive_up),      32'(m_state == 1));
    check_eq({where, " drive_down"},  32'(drive_down),    32'(m_state == 3));
    check_eq({where, " door_closed"}, 32'(door_closed),   32'(m_pos == 0));
    check_eq({where, " door_open"},   32'(door_open),     32'(m_pos == TM));
    check_eq({where, " fault"},       32'(fault),         32'(m_fault));
  endtask

  // Called at a falling edge: apply inputs, take one rising edge, then check.
  task automatic step(input bit up, input bit dn, input bit obs);
    motor_up   = up;
    motor_down = dn;
    obstacle   = obs;
    @(posedge clk);
    model_edge(up, dn, obs);
    @(negedge clk);
    check_all("step");
  endtask

  task automatic check_reset_values(input string where);
    check_eq({where, " rst state"},      32'(state),         32'd0);
    check_eq({where, " rst position"},   32'(door_position), 32'd0);
    check_eq({where, " rst drive_up"},   32'(drive_up),      32'd0);
    check_eq({where, " rst drive_down"}, 32'(drive_down),    32'd0);
    check_eq({where, " rst closed"},     32'(door_closed),   32'd1);
    check_eq({where, " rst open"},       32'(door_open),     32'd0);
    check_eq({where, " rst fault"},      32'(fault),         32'd0);
  endtask

  // Asserted between edges so the asynchronous path is what gets checked.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1 check_reset_values("async");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all("held reset");
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold;
    int sel;
    bit up, dn;
    reset = 1'b1; motor_up = 1'b0; motor_down = 1'b0; obstacle = 1'b0;
    model_reset();
    #1 check_reset_values("power-on");
    @(negedge clk);
    reset = 1'b0;

    // Full open with motor_up held.
    step(1, 0, 0);
    check_eq("open drive_up after 1 edge", 32'(drive_up), 32'd1);
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    check_eq("open final state", 32'(state), 32'd2);
    check_eq("open final pos", 32'(door_position), 32'd8);
    check_eq("open final drive_up", 32'(drive_up), 32'd0);

    // Close, obstacle at 5, auto-reverse back to open despite motor_down.
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    check_eq("close pos before obstacle", 32'(door_position), 32'd5);
    step(0, 1, 1);
    check_eq("obstacle -> DEAD", 32'(state), 32'd5);
    check_eq("DEAD drive_down", 32'(drive_down), 32'd0);
    step(0, 1, 0);
    step(0, 1, 0);
    check_eq("reverse state", 32'(state), 32'd1);
    check_eq("reverse pos held", 32'(door_position), 32'd5);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check_eq("reverse reaches OPEN", 32'(state), 32'd2);
    check_eq("reverse door_open", 32'(door_open), 32'd1);

    // Direction change while opening at 3.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    step(0, 1, 0);
    check_eq("turn DEAD pos", 32'(door_position), 32'd3);
    check_eq("turn DEAD drive_up", 32'(drive_up), 32'd0);
    step(0, 1, 0);
    step(0, 1, 0);
    check_eq("turn CLOSING", 32'(state), 32'd3);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check_eq("turn CLOSED", 32'(state), 32'd0);
    check_eq("turn door_closed", 32'(door_closed), 32'd1);

    // Release at 4 -> STOPPED, then close directly.
    apply_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    step(0, 0, 0);
    check_eq("stop state", 32'(state), 32'd4);
    check_eq("stop pos", 32'(door_position), 32'd4);
    step(0, 0, 0);
    step(0, 1, 0);
    check_eq("stop -> CLOSING direct", 32'(state), 32'd3);
    step(0, 1, 0);

    // Conflicting commands in CLOSED, then reset mid-close at 6.
    apply_reset();
    step(1, 1, 0);
    check_eq("fault set", 32'(fault), 32'd1);
    check_eq("fault state CLOSED", 32'(state), 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check_eq("mid-close pos", 32'(door_position), 32'd6);
    check_eq("mid-close drive_down", 32'(drive_down), 32'd1);
    check_eq("fault sticky", 32'(fault), 32'd1);
    apply_reset();

    // Randomized command bursts with sporadic obstacles and resets.
    for (int b = 0; b < 400; b++) begin
      if ($urandom_range(0, 59) == 0) apply_reset();
      sel  = int'($urandom_range(0, 19));
      up   = (sel < 8) || (sel == 18);
      dn   = (sel >= 8 && sel < 16) || (sel == 18);
      hold = int'($urandom_range(1, 10));
      for (int c = 0; c < hold; c++) step(up, dn, ($urandom_range(0, 6) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
